// File: rtl/board_io_ctrl.sv
// rtl/board_io_ctrl.sv - front-panel button/switch conditioning, LED drive and RGB PWM
//
// Purpose: synchronises, debounces and edge-detects NUM_BTN buttons and NUM_SW
// switches, registers NUM_LED plain LEDs and generates phase-aligned PWM on
// NUM_RGB RGB LEDs from double-buffered duty registers.
//
// Ports:
//   clk, reset_n                   system clock, asynchronous active-low reset
//   btn_in[NUM_BTN]                raw button pins (asynchronous)
//   sw_in[NUM_SW]                  raw switch pins (asynchronous)
//   btn_level/btn_press/btn_release  debounced level, 0->1 pulse, 1->0 pulse
//   sw_level/sw_change             debounced level, pulse on any change
//   led_in/led                     requested / registered plain-LED state
//   rgb_duty, rgb_duty_load        packed duties (R,G,B per channel), shadow load strobe
//   rgb_r/rgb_g/rgb_b              registered PWM drive per channel

module board_io_ctrl #(
  parameter int NUM_BTN         = 2,
  parameter int NUM_SW          = 4,
  parameter int NUM_LED         = 4,
  parameter int NUM_RGB         = 4,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int PWM_WIDTH       = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_BTN-1:0]               btn_in,
  input  logic [NUM_SW-1:0]                sw_in,
  output logic [NUM_BTN-1:0]               btn_level,
  output logic [NUM_BTN-1:0]               btn_press,
  output logic [NUM_BTN-1:0]               btn_release,
  output logic [NUM_SW-1:0]                sw_level,
  output logic [NUM_SW-1:0]                sw_change,
  input  logic [NUM_LED-1:0]               led_in,
  output logic [NUM_LED-1:0]               led,
  input  logic [NUM_RGB*3*PWM_WIDTH-1:0]   rgb_duty,
  input  logic                             rgb_duty_load,
  output logic [NUM_RGB-1:0]               rgb_r,
  output logic [NUM_RGB-1:0]               rgb_g,
  output logic [NUM_RGB-1:0]               rgb_b
);

  localparam int NUM_IN = NUM_BTN + NUM_SW;
  localparam int CW     = $clog2(DEBOUNCE_CYCLES);
  localparam int DW     = NUM_RGB * 3 * PWM_WIDTH;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Buttons and switches share one conditioning path; switches sit above buttons.
  logic [NUM_IN-1:0] raw;
  logic [NUM_IN-1:0] sync1;
  logic [NUM_IN-1:0] sync2;
  logic [NUM_IN-1:0] level;
  logic [NUM_IN-1:0] rise;
  logic [NUM_IN-1:0] fall;
  logic [CW-1:0]     db_cnt [NUM_IN];

  assign raw = {sw_in, btn_in};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Any cycle where the synchronised input agrees with the level discards the
  // partial count, so only an uninterrupted disagreement of DEBOUNCE_CYCLES
  // cycles flips the level. Pulses are registered alongside the level flip.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
      rise  <= '0;
      fall  <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX) begin
          db_cnt[i] <= '0;
          level[i]  <= sync2[i];
          rise[i]   <= sync2[i];
          fall[i]   <= ~sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btn_level   = level[NUM_BTN-1:0];
  assign btn_press   = rise[NUM_BTN-1:0];
  assign btn_release = fall[NUM_BTN-1:0];
  assign sw_level    = level[NUM_IN-1:NUM_BTN];
  assign sw_change   = rise[NUM_IN-1:NUM_BTN] | fall[NUM_IN-1:NUM_BTN];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led <= '0;
    end else begin
      led <= led_in;
    end
  end

  // PWM: shared counter, shadow duties written by software, active duties
  // swapped in only at the period boundary so a period never mixes duties.
  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [DW-1:0]        duty_shadow;
  logic [DW-1:0]        duty_active;
  logic                 pwm_wrap;
  logic [NUM_RGB-1:0]   r_nxt;
  logic [NUM_RGB-1:0]   g_nxt;
  logic [NUM_RGB-1:0]   b_nxt;

  assign pwm_wrap = &pwm_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt     <= '0;
      duty_shadow <= '0;
      duty_active <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (rgb_duty_load) begin
        duty_shadow <= rgb_duty;
      end
      // A load on the wrap edge bypasses the shadow so it is not a period late.
      if (pwm_wrap) begin
        duty_active <= rgb_duty_load ? rgb_duty : duty_shadow;
      end
    end
  end

  always_comb begin
    r_nxt = '0;
    g_nxt = '0;
    b_nxt = '0;
    for (int i = 0; i < NUM_RGB; i++) begin
      r_nxt[i] = pwm_cnt < duty_active[(3*i)*PWM_WIDTH   +: PWM_WIDTH];
      g_nxt[i] = pwm_cnt < duty_active[(3*i+1)*PWM_WIDTH +: PWM_WIDTH];
      b_nxt[i] = pwm_cnt < duty_active[(3*i+2)*PWM_WIDTH +: PWM_WIDTH];
    end
  end

  // Registered compare keeps outputs glitch-free and all colours phase-aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_r <= '0;
      rgb_g <= '0;
      rgb_b <= '0;
    end else begin
      rgb_r <= r_nxt;
      rgb_g <= g_nxt;
      rgb_b <= b_nxt;
    end
  end

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb/tb_board_io_ctrl.sv - directed self-checking bench for board_io_ctrl

module tb_board_io_ctrl;

  localparam int NB = 2;
  localparam int NS = 4;
  localparam int NL = 4;
  localparam int NR = 4;
  localparam int DB = 8;
  localparam int W  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NB-1:0]     btn_in;
  logic [NS-1:0]     sw_in;
  logic [NB-1:0]     btn_level, btn_press, btn_release;
  logic [NS-1:0]     sw_level, sw_change;
  logic [NL-1:0]     led_in, led;
  logic [NR*3*W-1:0] rgb_duty;
  logic              rgb_duty_load;
  logic [NR-1:0]     rgb_r, rgb_g, rgb_b;

  int vectors     = 0;
  int miscompares = 0;

  // Reference PWM phase: edges since reset release, modulo 2^W.
  logic [W-1:0] m_cnt;

  board_io_ctrl #(
    .NUM_BTN(NB), .NUM_SW(NS), .NUM_LED(NL), .NUM_RGB(NR),
    .DEBOUNCE_CYCLES(DB), .PWM_WIDTH(W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_in(btn_in), .sw_in(sw_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .sw_level(sw_level), .sw_change(sw_change),
    .led_in(led_in), .led(led),
    .rgb_duty(rgb_duty), .rgb_duty_load(rgb_duty_load),
    .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_cnt <= '0;
    else          m_cnt <= m_cnt + 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input logic [W-1:0] v);
    int n = 0;
    while (m_cnt != v && n < 40) begin
      step();
      n++;
    end
    if (m_cnt != v) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_cnt: timed out waiting for phase %0d", v);
    end
  endtask

  task automatic set_duty(input int ch, input logic [W-1:0] r, input logic [W-1:0] g,
                          input logic [W-1:0] b);
    rgb_duty[(3*ch)*W   +: W] = r;
    rgb_duty[(3*ch+1)*W +: W] = g;
    rgb_duty[(3*ch+2)*W +: W] = b;
  endtask

  // Counts high cycles on channel 1 over one full period starting at phase 0.
  task automatic count_period(input string tag, input int er, input int eg, input int eb);
    int r = 0, g = 0, b = 0, other = 0, first_r = 0;
    wait_cnt(0);
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 0) first_r = int'(rgb_r[1]);
      r += int'(rgb_r[1]);
      g += int'(rgb_g[1]);
      b += int'(rgb_b[1]);
      other += int'(rgb_r[0]) + int'(rgb_g[2]) + int'(rgb_b[3]);
    end
    check({tag, "_r_count"}, r, er);
    check({tag, "_g_count"}, g, eg);
    check({tag, "_b_count"}, b, eb);
    check({tag, "_r_first"}, first_r, (er > 0) ? 1 : 0);
    check({tag, "_other_ch"}, other, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi;
    int n;
    reset_n       = 1'b0;
    btn_in        = '0;
    sw_in         = '0;
    led_in        = '0;
    rgb_duty      = '0;
    rgb_duty_load = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("rst_btn_level", btn_level, 0);
    check("rst_sw_level", sw_level, 0);
    check("rst_led", led, 0);
    check("rst_rgb", {rgb_r, rgb_g, rgb_b}, 0);
    reset_n = 1'b1;

    // LED register latency
    led_in = 4'b1010;
    check("led_pre", led, 4'b0000);
    step();
    check("led_post", led, 4'b1010);

    // Button 0 press: visible after the 10th edge following the change
    btn_in[0] = 1'b1;
    for (int k = 0; k < 13; k++) begin
      step();
      check($sformatf("b0_level_e%0d", k), btn_level[0], k >= 9);
      check($sformatf("b0_press_e%0d", k), btn_press[0], k == 9);
      check($sformatf("b0_release_e%0d", k), btn_release, 0);
    end

    // 5-cycle glitch on switch 2 must vanish
    sw_in[2] = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step();
      if (k == 4) sw_in[2] = 1'b0;
      check($sformatf("glitch_level_%0d", k), sw_level, 0);
      check($sformatf("glitch_change_%0d", k), sw_change, 0);
    end

    // Button 1 press, then release pulse
    btn_in[1] = 1'b1;
    repeat (12) step();
    check("b1_level_high", btn_level[1], 1'b1);
    btn_in[1] = 1'b0;
    for (int k = 0; k < 13; k++) begin
      step();
      check($sformatf("b1_level_e%0d", k), btn_level[1], k < 9);
      check($sformatf("b1_release_e%0d", k), btn_release[1], k == 9);
      check($sformatf("b1_press_e%0d", k), btn_press[1], 1'b0);
    end

    // PWM: outputs idle before any load
    check("pwm_idle", {rgb_r, rgb_g, rgb_b}, 0);

    // First load: R=10, G=0, B=15 on channel 1
    wait_cnt(3);
    set_duty(1, 4'd10, 4'd0, 4'd15);
    rgb_duty_load = 1'b1;
    step();
    rgb_duty_load = 1'b0;
    count_period("duty10", 10, 0, 15);

    // Mid-period load of R=5: rest of this period still uses 10
    wait_cnt(6);
    set_duty(1, 4'd5, 4'd0, 4'd15);
    rgb_duty_load = 1'b1;
    step();
    rgb_duty_load = 1'b0;
    hi = int'(rgb_r[1]);
    n = 0;
    while (m_cnt != 0 && n < 20) begin
      step();
      hi += int'(rgb_r[1]);
      n++;
    end
    check("mid_load_old_duty", hi, 4);
    count_period("duty5", 5, 0, 15);

    // Load exactly on the wrap edge: effective in that very period
    wait_cnt(15);
    set_duty(1, 4'd3, 4'd0, 4'd15);
    rgb_duty_load = 1'b1;
    step();
    rgb_duty_load = 1'b0;
    count_period("wrap_load", 3, 0, 15);

    // Reset mid-debounce and mid-PWM period
    sw_in[0] = 1'b1;
    repeat (4) step();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_btn_level", btn_level, 0);
    check("async_sw", {sw_level, sw_change}, 0);
    check("async_led", led, 0);
    check("async_rgb", {rgb_r, rgb_g, rgb_b}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("rr_sw_level_e%0d", k), sw_level, (k >= 9) ? 4'b0001 : 4'b0000);
      check($sformatf("rr_sw_change_e%0d", k), sw_change, (k == 9) ? 4'b0001 : 4'b0000);
      check($sformatf("rr_btn_level_e%0d", k), btn_level, (k >= 9) ? 2'b01 : 2'b00);
      check($sformatf("rr_btn_press_e%0d", k), btn_press, (k == 9) ? 2'b01 : 2'b00);
      check($sformatf("rr_rgb_e%0d", k), {rgb_r, rgb_g, rgb_b}, 0);
    end
    check("rr_led", led, 4'b1010);
    repeat (10) step();
    check("rr_rgb_late", {rgb_r, rgb_g, rgb_b}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
